// File: rtl/fork_masked_pkg.sv
// fork_masked_pkg
//   Shared constants for the masked eager fork slice: the default channel
//   count and payload width used by the interface and the top-level.
//   No ports; imported by the other files of this block.
package fork_masked_pkg;

  localparam int DEFAULT_SIZE      = 2;
  localparam int DEFAULT_DATA_TYPE = 32;

endpackage

// File: rtl/fork_masked_if.sv
// fork_masked_if
//   Handshake bundle for the masked eager fork: one input channel carrying a
//   payload plus destination mask, and SIZE output channels sharing that
//   payload.
//   Signals:
//     ins        - input payload (DATA_TYPE bits)
//     ins_mask   - destination mask, bit i selects output i
//     ins_valid  - input token present
//     ins_ready  - input token consumed this cycle
//     outs       - SIZE payload slices, channel i at [(i+1)*DATA_TYPE-1 : i*DATA_TYPE]
//     outs_valid - per-output valid
//     outs_ready - per-output ready
//   Modports:
//     master - the environment side (drives the input token and output readies)
//     slave  - the fork itself
interface fork_masked_if #(
  parameter int SIZE      = fork_masked_pkg::DEFAULT_SIZE,
  parameter int DATA_TYPE = fork_masked_pkg::DEFAULT_DATA_TYPE
);
  import fork_masked_pkg::*;

  logic [DATA_TYPE-1:0]      ins;
  logic [SIZE-1:0]           ins_mask;
  logic                      ins_valid;
  logic                      ins_ready;
  logic [SIZE*DATA_TYPE-1:0] outs;
  logic [SIZE-1:0]           outs_valid;
  logic [SIZE-1:0]           outs_ready;

  modport master (
    output ins, ins_mask, ins_valid, outs_ready,
    input  ins_ready, outs, outs_valid
  );

  modport slave (
    input  ins, ins_mask, ins_valid, outs_ready,
    output ins_ready, outs, outs_valid
  );

endinterface

// File: rtl/fork_masked_block.sv
// fork_mask_register_block
//   Per-output bookkeeping of the masked eager fork. Holds one "sent" flag
//   recording that this output already took the token currently presented.
//   Ports:
//     clk, rst     - clock and synchronous active-high reset
//     ins_valid    - input token present
//     sel          - this output's mask bit for the current token
//     outs_ready   - this output's ready
//     backpressure - token present but not completing this cycle
//     outs_valid   - this output's valid
//     blockStop    - this output is selected, still owes a transfer and is stalling
//
// or_n
//   Plain OR reduction over SIZE bits.
//   Ports: ins (SIZE bits) in, outs (1 bit) out.
module fork_mask_register_block import fork_masked_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic ins_valid,
  input  logic sel,
  input  logic outs_ready,
  input  logic backpressure,
  output logic outs_valid,
  output logic blockStop
);

  logic sent_q;
  logic sent_d;

  assign outs_valid = ins_valid & sel & ~sent_q;
  assign blockStop  = outs_valid & ~outs_ready;

  // The flag only accumulates while the token is stuck; once the token
  // completes (or no token is present) every flag returns to zero, so an
  // output transferring in the completing cycle never leaves its flag set.
  always_comb begin
    sent_d = 1'b0;
    if (backpressure) begin
      sent_d = sent_q | (outs_valid & outs_ready);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sent_q <= 1'b0;
    end else begin
      sent_q <= sent_d;
    end
  end

endmodule

module or_n #(
  parameter int SIZE = 2
) (
  input  logic [SIZE-1:0] ins,
  output logic            outs
);

  assign outs = |ins;

endmodule

// File: rtl/fork_masked.sv
// fork_masked
//   Eager fork with data and a per-token destination mask. The input token
//   is broadcast to every output selected by ins_mask; each selected output
//   may accept in a different cycle, and the input is consumed only once all
//   selected outputs have taken it. All outputs are combinational from the
//   inputs and the per-output sent flags; latency is zero.
//   Ports:
//     clk, rst - clock and synchronous active-high reset
//     bus      - fork_masked_if slave modport (input token, SIZE outputs)
module fork_masked import fork_masked_pkg::*; #(
  parameter int SIZE      = DEFAULT_SIZE,
  parameter int DATA_TYPE = DEFAULT_DATA_TYPE
) (
  input logic          clk,
  input logic          rst,
  fork_masked_if.slave bus
);

  logic [SIZE-1:0] block_stop;
  logic [SIZE-1:0] outs_valid_w;
  logic            any_stop;
  logic            ins_ready_w;
  logic            backpressure;

  // Payload fan-out is pure wiring: every channel sees the input payload.
  assign bus.outs       = {SIZE{bus.ins}};
  assign bus.outs_valid = outs_valid_w;
  assign bus.ins_ready  = ins_ready_w;

  assign ins_ready_w  = ~any_stop;
  assign backpressure = bus.ins_valid & ~ins_ready_w;

  for (genvar i = 0; i < SIZE; i++) begin : g_blk
    fork_mask_register_block u_blk (
      .clk          (clk),
      .rst          (rst),
      .ins_valid    (bus.ins_valid),
      .sel          (bus.ins_mask[i]),
      .outs_ready   (bus.outs_ready[i]),
      .backpressure (backpressure),
      .outs_valid   (outs_valid_w[i]),
      .blockStop    (block_stop[i])
    );
  end

  or_n #(.SIZE(SIZE)) u_stop_or (
    .ins  (block_stop),
    .outs (any_stop)
  );

endmodule

// File: tb/tb_fork_masked.sv
// tb_fork_masked
//   Bench for fork_masked with SIZE=3, DATA_TYPE=8. Directed scenarios plus
//   randomized tokens, checked against a token-level model: the model tracks
//   which outputs already received the current token and a per-output queue
//   of payloads each output is still owed.
module tb_fork_masked;
  import fork_masked_pkg::*;

  localparam int N = 3;
  localparam int W = 8;

  logic clk;
  logic rst;

  fork_masked_if #(.SIZE(N), .DATA_TYPE(W)) bus ();

  fork_masked #(.SIZE(N), .DATA_TYPE(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  // Outputs that already took the current token.
  logic [N-1:0] gotIt = '0;
  // Payloads each output is still owed (random phase only).
  logic [W-1:0] owed [N][$];
  bit           useScoreboard = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, then advance
  // the model across the rising edge.
  task automatic applyStimulus(input logic [W-1:0] d, input logic [N-1:0] m,
                               input logic v, input logic [N-1:0] r, input logic rs);
    logic [N-1:0] expValid;
    logic         expReady;
    logic [W-1:0] owedData;
    bus.ins        = d;
    bus.ins_mask   = m;
    bus.ins_valid  = v;
    bus.outs_ready = r;
    rst            = rs;
    @(negedge clk);
    expValid = v ? (m & ~gotIt) : '0;
    expReady = ((expValid & ~r) == '0);
    checkOutput("outs_valid", 32'(bus.outs_valid), 32'(expValid));
    checkOutput("ins_ready", 32'(bus.ins_ready), 32'(expReady));
    for (int i = 0; i < N; i++) begin
      if (expValid[i]) begin
        checkOutput($sformatf("outs[%0d]", i), 32'(bus.outs[i*W +: W]), 32'(d));
      end
      if (useScoreboard && bus.outs_valid[i] && r[i]) begin
        if (owed[i].size() == 0) begin
          checkOutput($sformatf("unexpected transfer out%0d", i), 32'(bus.outs[i*W +: W]), 32'hFFFF_FFFF);
        end else begin
          owedData = owed[i].pop_front();
          checkOutput($sformatf("delivered out%0d", i), 32'(bus.outs[i*W +: W]), 32'(owedData));
        end
      end
    end
    @(posedge clk);
    if (rs || !v || expReady) gotIt = '0;
    else                      gotIt = gotIt | (expValid & r);
    #1;
  endtask

  initial begin
    logic [W-1:0] tokData;
    logic [N-1:0] tokMask;
    bit           pending;
    bit           tokValid;
    logic [N-1:0] expValid;

    bus.ins = '0; bus.ins_mask = '0; bus.ins_valid = 1'b0; bus.outs_ready = '0;
    rst = 1'b1;

    // Reset then idle.
    applyStimulus(8'h00, 3'b000, 1'b0, 3'b000, 1'b1);
    applyStimulus(8'h00, 3'b000, 1'b0, 3'b000, 1'b1);
    applyStimulus(8'h00, 3'b000, 1'b0, 3'b000, 1'b0);

    // Broadcast with every output ready: completes in one cycle.
    applyStimulus(8'hA5, 3'b111, 1'b1, 3'b111, 1'b0);
    applyStimulus(8'h00, 3'b000, 1'b0, 3'b111, 1'b0);

    // Staggered acceptance.
    applyStimulus(8'h3C, 3'b111, 1'b1, 3'b001, 1'b0);
    bus.outs_ready = 3'b100;
    #1;
    checkOutput("stagger c1 valid", 32'(bus.outs_valid), 32'h6);
    applyStimulus(8'h3C, 3'b111, 1'b1, 3'b100, 1'b0);
    bus.outs_ready = 3'b010;
    #1;
    checkOutput("stagger c2 valid", 32'(bus.outs_valid), 32'h2);
    checkOutput("stagger c2 ready", 32'(bus.ins_ready), 32'h1);
    applyStimulus(8'h3C, 3'b111, 1'b1, 3'b010, 1'b0);

    // Partial mask: out1 never valid, completes once selected outputs ready.
    applyStimulus(8'h5A, 3'b101, 1'b1, 3'b010, 1'b0);
    applyStimulus(8'h5A, 3'b101, 1'b1, 3'b111, 1'b0);

    // Zero mask then back-to-back tokens.
    applyStimulus(8'h01, 3'b000, 1'b1, 3'b111, 1'b0);
    applyStimulus(8'h02, 3'b011, 1'b1, 3'b111, 1'b0);
    applyStimulus(8'h03, 3'b011, 1'b1, 3'b111, 1'b0);

    // Reset mid-token: out0 takes it, out1 stalls, reset re-arms both.
    applyStimulus(8'h77, 3'b011, 1'b1, 3'b001, 1'b0);
    applyStimulus(8'h77, 3'b011, 1'b1, 3'b000, 1'b0);
    applyStimulus(8'h77, 3'b011, 1'b1, 3'b000, 1'b1);
    bus.outs_ready = 3'b000;
    #1;
    checkOutput("after reset valid", 32'(bus.outs_valid), 32'h3);
    applyStimulus(8'h77, 3'b011, 1'b1, 3'b011, 1'b0);

    // Randomized tokens; the producer holds each token until it completes.
    useScoreboard = 1;
    pending  = 0;
    tokData  = '0;
    tokMask  = '0;
    tokValid = 0;
    for (int c = 0; c < 600; c++) begin
      if (!pending) begin
        tokValid = ($urandom_range(0, 4) != 0);
        if (tokValid) begin
          tokData = W'($urandom);
          tokMask = N'($urandom);
          for (int i = 0; i < N; i++) if (tokMask[i]) owed[i].push_back(tokData);
          pending = 1;
        end
      end
      expValid = tokValid ? (tokMask & ~gotIt) : '0;
      begin
        logic [N-1:0] r;
        r = N'($urandom);
        applyStimulus(tokData, tokMask, tokValid, r, 1'b0);
        if (tokValid && ((expValid & ~r) == '0)) begin
          pending  = 0;
          tokValid = 0;
        end
      end
    end
    // Drain any token still pending with everything ready.
    if (pending) applyStimulus(tokData, tokMask, 1'b1, 3'b111, 1'b0);
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("owed left out%0d", i), 32'(owed[i].size()), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
